// File: rtl/exu_seq_pkg.sv
// rtl/exu_seq_pkg.sv - op encodings, status codes and FSM states shared by the execute unit
package exu_seq_pkg;

    localparam logic [5:0] ALU_ADD    = 6'd0;
    localparam logic [5:0] ALU_SUB    = 6'd1;
    localparam logic [5:0] ALU_AND    = 6'd2;
    localparam logic [5:0] ALU_OR     = 6'd3;
    localparam logic [5:0] ALU_XOR    = 6'd4;
    localparam logic [5:0] ALU_SLL    = 6'd5;
    localparam logic [5:0] ALU_SRL    = 6'd6;
    localparam logic [5:0] ALU_SRA    = 6'd7;
    localparam logic [5:0] ALU_SLT    = 6'd8;
    localparam logic [5:0] ALU_SLTI   = 6'd9;
    localparam logic [5:0] ALU_SLTU   = 6'd10;
    localparam logic [5:0] ALU_SLTIU  = 6'd11;
    localparam logic [5:0] ALU_LUI    = 6'd12;
    localparam logic [5:0] ALU_MFHI   = 6'd13;
    localparam logic [5:0] ALU_MFLO   = 6'd14;
    localparam logic [5:0] ALU_MULT   = 6'd15;
    localparam logic [5:0] ALU_MULTU  = 6'd16;
    localparam logic [5:0] ALU_DIV    = 6'd17;
    localparam logic [5:0] ALU_DIVU   = 6'd18;
    localparam logic [5:0] ALU_LW     = 6'd19;
    localparam logic [5:0] ALU_SW     = 6'd20;
    localparam logic [5:0] ALU_JAL    = 6'd21;
    localparam logic [5:0] ALU_BGEZAL = 6'd22;
    localparam logic [5:0] ALU_BREAK  = 6'd23;

    localparam logic [1:0] STATUS_OK    = 2'b00;
    localparam logic [1:0] STATUS_BREAK = 2'b01;
    localparam logic [1:0] STATUS_UNK   = 2'b10;

    // muldiv engine op: bit1 = divide, bit0 = unsigned
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/exu_muldiv.sv
// rtl/exu_muldiv.sv - iterative shift-add multiplier / restoring divider, one bit per cycle
//  start_i/op_i/a_i/b_i : launch (op bit1 = divide, bit0 = unsigned)
//  busy_o               : iterating
//  done_o               : one-cycle pulse, hi_o/lo_o valid from then until next start
module exu_muldiv import exu_seq_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic              busy_q, done_q, is_div_q, neg_q, rneg_q, dz_q;
    logic [CW-1:0]     cnt_q;
    // multiply: {upper partial sum, remaining multiplier}; divide: {remainder, quotient}
    logic [2*XLEN-1:0] p_q;
    logic [XLEN-1:0]   m_q;

    logic              sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN:0]   mul_ext;
    logic [2*XLEN-1:0] step, fin;

    always_comb begin
        sa      = !op_i[0] && a_i[XLEN-1];
        sb      = !op_i[0] && b_i[XLEN-1];
        mag_a   = sa ? -a_i : a_i;
        mag_b   = sb ? -b_i : b_i;

        sum     = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
        mul_ext = {sum, p_q[XLEN-1:0]};

        shifted = p_q[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, m_q};

        if (is_div_q) begin
            if (!diff[XLEN]) step = {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
            else             step = {shifted[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
        end else begin
            step = mul_ext[2*XLEN:1];
        end

        // sign fix-ups applied on the final step only
        fin = step;
        if (!is_div_q) begin
            if (neg_q) fin = -step;
        end else begin
            if (neg_q)  fin[XLEN-1:0]      = -step[XLEN-1:0];
            if (dz_q)   fin[XLEN-1:0]      = '1;
            if (rneg_q) fin[2*XLEN-1:XLEN] = -step[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                busy_q   <= 1'b1;
                cnt_q    <= '0;
                is_div_q <= op_i[1];
                neg_q    <= sa ^ sb;
                rneg_q   <= op_i[1] && sa;
                dz_q     <= op_i[1] && (b_i == '0);
                p_q      <= {{XLEN{1'b0}}, (op_i[1] ? mag_a : mag_b)};
                m_q      <= op_i[1] ? mag_b : mag_a;
            end else if (busy_q) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    p_q    <= fin;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    p_q <= step;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = p_q[2*XLEN-1:XLEN];
    assign lo_o   = p_q[XLEN-1:0];

endmodule

// File: rtl/exu_seq.sv
// rtl/exu_seq.sv - handshaked execute unit: registered ALU result, iterative muldiv into HI/LO
//  in_valid/in_ready   : decoded op (op_i, rega_i, regb_i, rt_data_i, regc_*, mem_*, masks)
//  out_valid/out_ready : registered result_o, mem_data_o, control copies, status_o
module exu_seq import exu_seq_pkg::*; #(
    parameter int XLEN    = 32,
    parameter int OPW     = 6,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPW-1:0]     op_i,
    input  logic [XLEN-1:0]    rega_i,
    input  logic [XLEN-1:0]    regb_i,
    input  logic [XLEN-1:0]    rt_data_i,
    input  logic               regc_wr_i,
    input  logic [RADDR_W-1:0] regc_addr_i,
    input  logic               mem_rd_i,
    input  logic               mem_wr_i,
    input  logic [3:0]         rmask_i,
    input  logic [3:0]         wmask_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result_o,
    output logic [XLEN-1:0]    mem_data_o,
    output logic               regc_wr_o,
    output logic [RADDR_W-1:0] regc_addr_o,
    output logic               mem_rd_o,
    output logic               mem_wr_o,
    output logic [3:0]         rmask_o,
    output logic [3:0]         wmask_o,
    output logic [1:0]         status_o
);
    localparam int SHW = $clog2(XLEN);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [XLEN-1:0]    result_q, result_d, mem_data_q, mem_data_d, hi_q, hi_d, lo_q, lo_d;
    logic               regc_wr_q, regc_wr_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [RADDR_W-1:0] regc_addr_q, regc_addr_d;
    logic [3:0]         rmask_q, rmask_d, wmask_q, wmask_d;
    logic [1:0]         status_q, status_d;

    logic [5:0]         op;
    logic [SHW-1:0]     sh;
    logic [XLEN-1:0]    alu_res;
    logic [1:0]         alu_status;
    logic               known, is_md, accept, md_start, md_busy, md_done;
    logic [1:0]         md_op;
    logic [XLEN-1:0]    md_hi, md_lo;

    assign op       = 6'(op_i);
    assign sh       = rega_i[SHW-1:0];
    assign in_ready = (state_q == S_IDLE) && !md_busy && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_md    = (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
    assign md_op    = {(op == ALU_DIV) || (op == ALU_DIVU), (op == ALU_MULTU) || (op == ALU_DIVU)};

    always_comb begin
        alu_res    = '0;
        alu_status = STATUS_OK;
        known      = 1'b1;
        case (op)
            ALU_ADD, ALU_LW, ALU_SW, ALU_JAL, ALU_BGEZAL: alu_res = rega_i + regb_i;
            ALU_SUB:   alu_res = rega_i - regb_i;
            ALU_AND:   alu_res = rega_i & regb_i;
            ALU_OR:    alu_res = rega_i | regb_i;
            ALU_XOR:   alu_res = rega_i ^ regb_i;
            ALU_SLL:   alu_res = regb_i << sh;
            ALU_SRL:   alu_res = regb_i >> sh;
            ALU_SRA:   alu_res = $signed(regb_i) >>> sh;
            ALU_SLT, ALU_SLTI:   alu_res = {{(XLEN-1){1'b0}}, $signed(rega_i) < $signed(regb_i)};
            ALU_SLTU, ALU_SLTIU: alu_res = {{(XLEN-1){1'b0}}, rega_i < regb_i};
            ALU_LUI:   alu_res = rega_i;
            ALU_MFHI:  alu_res = hi_q;
            ALU_MFLO:  alu_res = lo_q;
            ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: alu_res = '0;
            ALU_BREAK: begin
                alu_res    = rega_i + regb_i;
                alu_status = STATUS_BREAK;
            end
            default: begin
                known      = 1'b0;
                alu_status = STATUS_UNK;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        mem_data_d  = mem_data_q;
        regc_wr_d   = regc_wr_q;
        regc_addr_d = regc_addr_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        rmask_d     = rmask_q;
        wmask_d     = wmask_q;
        status_d    = status_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        md_start    = 1'b0;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_md) begin
                        md_start = 1'b1;
                        state_d  = S_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        mem_data_d  = rt_data_i;
                        regc_wr_d   = regc_wr_i && known;
                        regc_addr_d = regc_addr_i;
                        mem_rd_d    = mem_rd_i && known;
                        mem_wr_d    = mem_wr_i && known;
                        rmask_d     = rmask_i;
                        wmask_d     = wmask_i;
                        status_d    = alu_status;
                    end
                end
            end
            S_BUSY: begin
                // out_valid is already low here: entry required the previous result to drain
                if (md_done) begin
                    hi_d        = md_hi;
                    lo_d        = md_lo;
                    out_valid_d = 1'b1;
                    result_d    = '0;
                    mem_data_d  = '0;
                    regc_wr_d   = 1'b0;
                    regc_addr_d = '0;
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    rmask_d     = '0;
                    wmask_d     = '0;
                    status_d    = STATUS_OK;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            mem_data_q  <= '0;
            regc_wr_q   <= 1'b0;
            regc_addr_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rmask_q     <= '0;
            wmask_q     <= '0;
            status_q    <= STATUS_OK;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            mem_data_q  <= mem_data_d;
            regc_wr_q   <= regc_wr_d;
            regc_addr_q <= regc_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            rmask_q     <= rmask_d;
            wmask_q     <= wmask_d;
            status_q    <= status_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    exu_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .start_i (md_start),
        .op_i    (md_op),
        .a_i     (rega_i),
        .b_i     (regb_i),
        .busy_o  (md_busy),
        .done_o  (md_done),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    assign out_valid   = out_valid_q;
    assign result_o    = result_q;
    assign mem_data_o  = mem_data_q;
    assign regc_wr_o   = regc_wr_q;
    assign regc_addr_o = regc_addr_q;
    assign mem_rd_o    = mem_rd_q;
    assign mem_wr_o    = mem_wr_q;
    assign rmask_o     = rmask_q;
    assign wmask_o     = wmask_q;
    assign status_o    = status_q;

endmodule

// File: tb/tb_exu_seq.sv
// tb/tb_exu_seq.sv - directed table-driven bench for exu_seq
module tb_exu_seq;
    import exu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  op_i;
    logic [31:0] rega_i, regb_i, rt_data_i, result_o, mem_data_o;
    logic        regc_wr_i, mem_rd_i, mem_wr_i, regc_wr_o, mem_rd_o, mem_wr_o;
    logic [4:0]  regc_addr_i, regc_addr_o;
    logic [3:0]  rmask_i, wmask_i, rmask_o, wmask_o;
    logic [1:0]  status_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exu_seq #(.XLEN(32), .OPW(6), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_i(op_i), .rega_i(rega_i), .regb_i(regb_i), .rt_data_i(rt_data_i),
        .regc_wr_i(regc_wr_i), .regc_addr_i(regc_addr_i),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .rmask_i(rmask_i), .wmask_i(wmask_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .result_o(result_o), .mem_data_o(mem_data_o),
        .regc_wr_o(regc_wr_o), .regc_addr_o(regc_addr_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .rmask_o(rmask_o), .wmask_o(wmask_o),
        .status_o(status_o)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [1:0]  st;
        logic        wr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mf(input logic [5:0] op, input string nm, input logic [31:0] exp);
        op_i = op; rega_i = '0; regb_i = '0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({nm, " valid"}, out_valid, 1);
        chk(nm, result_o, exp);
    endtask

    task automatic run_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string nm);
        int n;
        logic held;
        op_i = op; rega_i = a; regb_i = b; regc_wr_i = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        held = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready) held = 1'b0;
            tick();
            n++;
        end
        chk({nm, " latency"}, n, 33);
        chk({nm, " in_ready low while busy"}, held, 1);
        chk({nm, " result zero"}, result_o, 0);
        chk({nm, " regc_wr zero"}, regc_wr_o, 0);
        mf(ALU_MFLO, {nm, " LO"}, exp_lo);
        mf(ALU_MFHI, {nm, " HI"}, exp_hi);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op_i = ALU_ADD;
        rega_i = '0; regb_i = '0; rt_data_i = '0; regc_wr_i = 1'b1; regc_addr_i = '0;
        mem_rd_i = 1'b1; mem_wr_i = 1'b0; rmask_i = 4'hF; wmask_i = 4'h3;

        vecs.push_back('{ALU_MFHI,  32'h0,        32'h0,        32'h0,        STATUS_OK,    1'b1});
        vecs.push_back('{ALU_MFLO,  32'h0,        32'h0,        32'h0,        STATUS_OK,    1'b1});
        vecs.push_back('{ALU_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        STATUS_OK,    1'b1});
        vecs.push_back('{ALU_SUB,   32'h5,        32'h7,        32'hFFFFFFFE, STATUS_OK,    1'b1});
        vecs.push_back('{ALU_SLT,   32'hFFFFFFFF, 32'h1,        32'h1,        STATUS_OK,    1'b1});
        vecs.push_back('{ALU_SLTIU, 32'hFFFFFFFF, 32'h1,        32'h0,        STATUS_OK,    1'b1});
        vecs.push_back('{ALU_SRA,   32'd35,       32'h80000000, 32'hF0000000, STATUS_OK,    1'b1});
        vecs.push_back('{ALU_SRL,   32'd4,        32'h80000000, 32'h08000000, STATUS_OK,    1'b1});
        vecs.push_back('{ALU_SLL,   32'd4,        32'h1,        32'h10,       STATUS_OK,    1'b1});
        vecs.push_back('{ALU_AND,   32'hF0F0,     32'hFF00,     32'hF000,     STATUS_OK,    1'b1});
        vecs.push_back('{ALU_XOR,   32'hF0F0,     32'hFF00,     32'h0FF0,     STATUS_OK,    1'b1});
        vecs.push_back('{ALU_SLTU,  32'h1,        32'hFFFFFFFF, 32'h1,        STATUS_OK,    1'b1});
        vecs.push_back('{ALU_SLTI,  32'hFFFFFFFB, 32'hFFFFFFFC, 32'h1,        STATUS_OK,    1'b1});
        vecs.push_back('{ALU_LUI,   32'h12340000, 32'h5,        32'h12340000, STATUS_OK,    1'b1});
        vecs.push_back('{ALU_BREAK, 32'h2,        32'h3,        32'h5,        STATUS_BREAK, 1'b1});
        vecs.push_back('{6'd63,     32'h1,        32'h1,        32'h0,        STATUS_UNK,   1'b0});

        repeat (3) tick();
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result_o, 0);
        chk("reset status", status_o, 0);
        chk("reset regc_wr", regc_wr_o, 0);
        rst = 1'b1;
        #1;
        chk("in_ready after reset", in_ready, 1);

        // back-to-back, one op per cycle
        foreach (vecs[i]) begin
            op_i = vecs[i].op; rega_i = vecs[i].a; regb_i = vecs[i].b;
            rt_data_i = 32'hA5000000 + i; regc_addr_i = 5'(i); in_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d in_ready", i), in_ready, 1);
            tick();
            chk($sformatf("vec%0d valid", i), out_valid, 1);
            chk($sformatf("vec%0d result", i), result_o, vecs[i].res);
            chk($sformatf("vec%0d status", i), status_o, vecs[i].st);
            chk($sformatf("vec%0d regc_wr", i), regc_wr_o, vecs[i].wr);
            chk($sformatf("vec%0d mem_rd", i), mem_rd_o, vecs[i].wr);
            chk($sformatf("vec%0d mem_data", i), mem_data_o, 32'hA5000000 + i);
            chk($sformatf("vec%0d regc_addr", i), regc_addr_o, 5'(i));
        end
        in_valid = 1'b0;
        tick();
        chk("drain out_valid", out_valid, 0);

        run_md(ALU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "MULT");
        run_md(ALU_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, "MULTU");
        run_md(ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "DIV");
        run_md(ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "DIV ovf");
        run_md(ALU_DIVU,  32'd9,        32'd0,        32'h00000009, 32'hFFFFFFFF, "DIVU0");
        tick();

        // backpressure
        out_ready = 1'b0;
        op_i = ALU_ADD; rega_i = 32'd1; regb_i = 32'd2; in_valid = 1'b1;
        tick();
        op_i = ALU_SUB; rega_i = 32'd10; regb_i = 32'd4;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp valid c%0d", c), out_valid, 1);
            chk($sformatf("bp result c%0d", c), result_o, 3);
            chk($sformatf("bp in_ready c%0d", c), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready on release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp next result", result_o, 6);
        chk("bp next valid", out_valid, 1);
        tick();

        // reset in the middle of a divide
        op_i = ALU_DIV; rega_i = 32'd100; regb_i = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        chk("midrst out_valid", out_valid, 0);
        rst = 1'b1;
        #1;
        chk("midrst in_ready", in_ready, 1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("midrst no result", seen, 0);
        mf(ALU_MFHI, "midrst HI", 32'h0);
        mf(ALU_MFLO, "midrst LO", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
